// File: rtl/alu_pkg.sv
// alu_pkg: operation codes, FSM state type and op classification shared by the ALU and its bench
package alu_pkg;
    localparam logic [4:0] OP_AND    = 5'b00000;
    localparam logic [4:0] OP_OR     = 5'b00001;
    localparam logic [4:0] OP_ADD    = 5'b00010;
    localparam logic [4:0] OP_SLL    = 5'b00011;
    localparam logic [4:0] OP_SLT    = 5'b00100;
    localparam logic [4:0] OP_SLTU   = 5'b00101;
    localparam logic [4:0] OP_SUB    = 5'b00110;
    localparam logic [4:0] OP_XOR    = 5'b00111;
    localparam logic [4:0] OP_SRL    = 5'b01000;
    localparam logic [4:0] OP_SRA    = 5'b01010;
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    // Every 1xxxx code runs through the iterative multiply/divide core.
    function automatic logic is_multicycle(input logic [4:0] ctrl);
        return ctrl[4];
    endfunction
endpackage

// File: rtl/mul_div_core.sv
// mul_div_core: iterative shift-add multiplier / restoring divider, one bit per cycle, N cycles per op
// Ports: clk, rst (sync, active high); i_start loads operands; i_op = alu_ctrl[2:0]
//        (bit2 divide; mul: 00 lo, 01 ss, 10 su, 11 uu; div: bit1 remainder, bit0 unsigned);
//        i_a/i_b operands; o_done high on the last iteration cycle with o_result valid then.
module mul_div_core #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [2:0]   i_op,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_done,
    output logic [N-1:0] o_result
);
    localparam int CW = $clog2(N);

    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_hi, r_lo, r_b, r_a;
    logic [2:0]    r_op;
    logic          r_neg_q, r_neg_r;

    logic          w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_ge, w_bz;
    logic [N-1:0]  w_a_mag, w_b_mag, w_diff, w_hi_n, w_lo_n, w_quo, w_rem;
    logic [N:0]    w_sum, w_sh;
    logic [2*N-1:0] w_prod, w_prod_s;

    // Operands are converted to magnitudes at start; signs are reapplied on the final cycle.
    assign w_a_sgn = i_op[2] ? ~i_op[0] : (i_op[1:0] == 2'b01 || i_op[1:0] == 2'b10);
    assign w_b_sgn = i_op[2] ? ~i_op[0] : (i_op[1:0] == 2'b01);
    assign w_a_neg = w_a_sgn & i_a[N-1];
    assign w_b_neg = w_b_sgn & i_b[N-1];
    assign w_a_mag = w_a_neg ? -i_a : i_a;
    assign w_b_mag = w_b_neg ? -i_b : i_b;

    // Multiply: r_hi accumulates, r_lo holds the multiplier and collects low product bits.
    assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    // Divide: r_hi is the partial remainder, r_lo shifts the dividend out and quotient in.
    assign w_sh   = {r_hi, r_lo[N-1]};
    assign w_ge   = w_sh >= {1'b0, r_b};
    assign w_diff = w_sh[N-1:0] - r_b;
    assign w_hi_n = r_op[2] ? (w_ge ? w_diff : w_sh[N-1:0]) : w_sum[N:1];
    assign w_lo_n = r_op[2] ? {r_lo[N-2:0], w_ge} : {w_sum[0], r_lo[N-1:1]};

    assign w_prod   = {w_hi_n, w_lo_n};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_quo    = r_neg_q ? -w_lo_n : w_lo_n;
    assign w_rem    = r_neg_r ? -w_hi_n : w_hi_n;
    assign w_bz     = r_b == '0;

    assign o_done   = r_busy && r_cnt == CW'(N - 1);
    assign o_result = r_op[2] ? (r_op[1] ? (w_bz ? r_a : w_rem) : (w_bz ? '1 : w_quo))
                              : (r_op[1:0] == 2'b00 ? w_prod_s[N-1:0] : w_prod_s[2*N-1:N]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_b     <= '0;
            r_a     <= '0;
            r_op    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= w_a_mag;
            r_b     <= w_b_mag;
            r_a     <= i_a;
            r_op    <= i_op;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
        end else if (r_busy) begin
            r_hi   <= w_hi_n;
            r_lo   <= w_lo_n;
            r_cnt  <= r_cnt + 1'b1;
            r_busy <= ~o_done;
        end
    end
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: valid/ready ALU with single-cycle integer ops and an iterative multiply/divide core
// Ports: clk, rst (sync, active high); in_valid/in_ready with rs1, rs2, alu_ctrl;
//        out_valid/out_ready with registered res, zf, negative; busy while iterating.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int N   = 32,
    parameter int SHW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] rs1,
    input  logic [N-1:0] rs2,
    input  logic [4:0]   alu_ctrl,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] res,
    output logic         zf,
    output logic         negative,
    output logic         busy
);
    state_t         r_state, w_state_n;
    logic [N-1:0]   r_res, w_alu, w_core_res, w_val;
    logic           r_zf, r_neg;
    logic           w_accept, w_multi, w_core_done, w_load;
    logic [SHW-1:0] w_shamt;

    assign in_ready  = r_state == S_IDLE;
    assign busy      = r_state == S_CALC;
    assign out_valid = r_state == S_DONE;
    assign res       = r_res;
    assign zf        = r_zf;
    assign negative  = r_neg;

    assign w_accept = in_valid & in_ready;
    assign w_multi  = is_multicycle(alu_ctrl);
    assign w_shamt  = rs2[SHW-1:0];

    mul_div_core #(.N(N)) u_core (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_accept & w_multi),
        .i_op     (alu_ctrl[2:0]),
        .i_a      (rs1),
        .i_b      (rs2),
        .o_done   (w_core_done),
        .o_result (w_core_res)
    );

    always_comb begin
        w_alu = '0;
        case (alu_ctrl)
            OP_ADD:  w_alu = rs1 + rs2;
            OP_SUB:  w_alu = rs1 - rs2;
            OP_AND:  w_alu = rs1 & rs2;
            OP_OR:   w_alu = rs1 | rs2;
            OP_XOR:  w_alu = rs1 ^ rs2;
            OP_SLL:  w_alu = rs1 << w_shamt;
            OP_SRL:  w_alu = rs1 >> w_shamt;
            OP_SRA:  w_alu = $signed(rs1) >>> w_shamt;
            OP_SLT:  w_alu = {{(N-1){1'b0}}, $signed(rs1) < $signed(rs2)};
            OP_SLTU: w_alu = {{(N-1){1'b0}}, rs1 < rs2};
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_n = w_multi ? S_CALC : S_DONE;
            S_CALC:  if (w_core_done) w_state_n = S_DONE;
            S_DONE:  if (out_ready) w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    // The result register loads once per op: at accept for single-cycle ops, on the last iteration otherwise.
    assign w_load = (w_accept & ~w_multi) | (busy & w_core_done);
    assign w_val  = busy ? w_core_res : w_alu;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_res   <= '0;
            r_zf    <= 1'b1;
            r_neg   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (w_load) begin
                r_res <= w_val;
                r_zf  <= w_val == '0;
                r_neg <= w_val[N-1];
            end
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vector table plus backpressure and mid-op reset sequences
module tb_alu_muldiv;
    import alu_pkg::*;
    localparam int N = 32;

    logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [N-1:0] rs1 = '0, rs2 = '0;
    logic [4:0]   alu_ctrl = '0;
    logic         in_ready, out_valid, zf, negative, busy;
    logic [N-1:0] res;

    int checks = 0, errors = 0;

    typedef struct {
        logic [4:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    vec_t vecs[$];

    alu_muldiv #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .alu_ctrl(alu_ctrl), .out_valid(out_valid),
        .out_ready(out_ready), .res(res), .zf(zf), .negative(negative), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic do_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output int lat, output int bcnt);
        @(negedge clk);
        alu_ctrl = c; rs1 = a; rs2 = b; in_valid = 1'b1;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        bcnt = 0;
        while (!out_valid && lat < 200) begin
            bcnt += int'(busy);
            @(posedge clk); #1;
            lat++;
        end
        r = res;
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("consumed_out_valid", 32'(out_valid), 32'd0);
        chk("consumed_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] r;
        int lat, bcnt, seen;

        vecs.push_back(vec_t'{OP_ADD,    32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});
        vecs.push_back(vec_t'{OP_SUB,    32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1});
        vecs.push_back(vec_t'{OP_AND,    32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1});
        vecs.push_back(vec_t'{OP_OR,     32'h000000F0, 32'h00000F00, 32'h00000FF0, 1});
        vecs.push_back(vec_t'{OP_XOR,    32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1});
        vecs.push_back(vec_t'{OP_SLL,    32'h00000001, 32'h00000021, 32'h00000002, 1});
        vecs.push_back(vec_t'{OP_SRL,    32'h80000000, 32'h00000024, 32'h08000000, 1});
        vecs.push_back(vec_t'{OP_SRA,    32'h80000000, 32'h00000024, 32'hF8000000, 1});
        vecs.push_back(vec_t'{OP_SLT,    32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1});
        vecs.push_back(vec_t'{OP_SLTU,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});
        vecs.push_back(vec_t'{5'b01111,  32'h12345678, 32'h00000001, 32'h00000000, 1});
        vecs.push_back(vec_t'{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33});
        vecs.push_back(vec_t'{OP_MUL,    32'h80000000, 32'h80000000, 32'h00000000, 33});
        vecs.push_back(vec_t'{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
        vecs.push_back(vec_t'{OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33});
        vecs.push_back(vec_t'{OP_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 33});
        vecs.push_back(vec_t'{OP_MULH,   32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFF, 33});
        vecs.push_back(vec_t'{OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33});
        vecs.push_back(vec_t'{OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33});
        vecs.push_back(vec_t'{OP_DIVU,   32'h00000005, 32'h00000000, 32'hFFFFFFFF, 33});
        vecs.push_back(vec_t'{OP_REMU,   32'h00000005, 32'h00000000, 32'h00000005, 33});
        vecs.push_back(vec_t'{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33});
        vecs.push_back(vec_t'{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33});
        vecs.push_back(vec_t'{OP_DIVU,   32'h00000064, 32'h00000007, 32'h0000000E, 33});
        vecs.push_back(vec_t'{OP_REMU,   32'h00000064, 32'h00000007, 32'h00000002, 33});
        vecs.push_back(vec_t'{OP_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33});
        vecs.push_back(vec_t'{OP_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33});
        vecs.push_back(vec_t'{OP_DIV,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 33});
        vecs.push_back(vec_t'{OP_REM,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 33});

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res", res, 32'd0);
        chk("rst_zf", 32'(zf), 32'd1);
        chk("rst_negative", 32'(negative), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            do_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, r, lat, bcnt);
            chk($sformatf("res[%0d]", i), r, vecs[i].exp);
            chk($sformatf("zf[%0d]", i), 32'(zf), 32'(vecs[i].exp == 32'd0));
            chk($sformatf("neg[%0d]", i), 32'(negative), 32'(vecs[i].exp[31]));
            chk($sformatf("latency[%0d]", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("busy_cycles[%0d]", i), 32'(bcnt), 32'(vecs[i].lat - 1));
            consume();
        end

        do_op(OP_ADD, 32'd3, 32'd4, r, lat, bcnt);
        chk("bp_res", r, 32'd7);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1; alu_ctrl = OP_SUB; rs1 = 32'(k); rs2 = 32'd9;
            @(posedge clk); #1;
            chk($sformatf("bp_out_valid[%0d]", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp_in_ready[%0d]", k), 32'(in_ready), 32'd0);
            chk($sformatf("bp_res_hold[%0d]", k), res, 32'd7);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_consumed", 32'(out_valid), 32'd0);
        chk("bp_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk("bp_no_queue", 32'(out_valid), 32'd0);

        @(negedge clk);
        alu_ctrl = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("abort_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_res", res, 32'd0);
        chk("abort_zf", 32'(zf), 32'd1);
        chk("abort_negative", 32'(negative), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            seen |= int'(out_valid);
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        do_op(OP_DIVU, 32'd100, 32'd7, r, lat, bcnt);
        chk("after_abort_res", r, 32'h0000000E);
        chk("after_abort_latency", 32'(lat), 32'd33);
        consume();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter: N, default 32, datapath width in bits (power of two, 8..64).
REQ-002 Parameter: SHW, default $clog2(N), shift-amount width; derived, not overridden.
REQ-003 Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  block accepts an op this cycle.
- rs1  input  N  operand A.
- rs2  input  N  operand B.
- alu_ctrl  input  5  operation select.
- out_valid  output  1  result presented.
- out_ready  input  1  consumer takes result.
- res  output  N  result.
- zf  output  1  res equals zero.
- negative  output  1  res[N-1].
- busy  output  1  iterative op in progress.
REQ-004 The block SHALL use one clock; reset SHALL be synchronous and active-high on rst.

Function
REQ-005 alu_ctrl codes SHALL be: ADD 00010, SUB 00110, AND 00000, OR 00001, SLL 00011, SLT 00100 (signed), SLTU 00101, XOR 00111, SRL 01000, SRA 01010 (arithmetic), MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111; any other code SHALL yield res 0.
REQ-006 Shifts SHALL use rs2[SHW-1:0] only; SLT/SLTU SHALL return 1 or 0 zero-extended to N.
REQ-007 An op SHALL be accepted on a rising edge with in_valid and in_ready both high; rs1, rs2, alu_ctrl SHALL be captured then.
REQ-008 State machine IDLE, CALC, DONE: IDLE->DONE on accepting a single-cycle op (codes 0xxxx); IDLE->CALC on accepting a 1xxxx op; CALC->DONE after exactly N iteration cycles; DONE->IDLE when out_ready is high.
REQ-009 in_ready SHALL be high only in IDLE; busy SHALL be high only in CALC; out_valid SHALL be high only in DONE.
REQ-010 Latency from accept edge to out_valid: 1 cycle for single-cycle ops, N+1 cycles for multiply/divide ops.
REQ-011 Multiply SHALL be iterative shift-add (one bit per cycle) on a 2N-bit product; MUL returns low N bits, MULH/MULHSU/MULHU return high N bits with signed*signed, signed*unsigned, unsigned*unsigned operands.
REQ-012 Divide SHALL be iterative restoring (one quotient bit per cycle) on magnitudes, with signs fixed up at completion; remainder sign SHALL follow rs1.
REQ-013 Divide by zero: DIV/DIVU SHALL return all ones; REM/REMU SHALL return rs1; still N+1 cycles latency.
REQ-014 Signed overflow (rs1 = 1 followed by N-1 zeros, rs2 = all ones): DIV SHALL return rs1; REM SHALL return 0.
REQ-015 res, zf, negative SHALL be registered and held stable while out_valid high and out_ready low.
REQ-016 in_valid SHALL be ignored outside IDLE; no op SHALL be queued.

Reset
REQ-017 On rst high at a clock edge: state IDLE, res 0, zf 1, negative 0, out_valid 0, busy 0, iteration counter 0.
REQ-018 rst during CALC or DONE SHALL abort the op without producing out_valid; in_ready SHALL be high the cycle after rst deasserts.

Structure
REQ-019 Package alu_pkg SHALL hold the alu_ctrl code constants, the state enum typedef, and an is_multicycle function.
REQ-020 The iterative multiply/divide datapath SHALL be one sub-module, mul_div_core, with start/done handshake and N-cycle fixed latency; single-cycle ops SHALL stay in alu_muldiv.

Verification (N=32)
REQ-021 ADD rs1=0xFFFFFFFF, rs2=1 -> 1 cycle later out_valid, res 0, zf 1, negative 0.
REQ-022 SRA rs1=0x80000000, rs2=0x00000024 (shift 4) -> res 0xF8000000, negative 1; SLT 0xFFFFFFFF vs 1 -> 1, SLTU -> 0.
REQ-023 MULH rs1=0x80000000, rs2=0x80000000 -> res 0x40000000 at cycle 33 after accept; MUL same operands -> 0; busy high cycles 1..32.
REQ-024 DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-025 Backpressure: out_ready low 5 cycles in DONE -> res stable, in_ready low, in_valid pulses ignored; result consumed on first out_ready high.
REQ-026 rst asserted at cycle 10 of a DIVU -> no out_valid, outputs at reset values, next op accepted and correct.
